spdif_relay_ctrl: RTL and testbench
===================================

// Module: spdif_relay_ctrl
// PURPOSE
//  Sequences the S/PDIF relay datapath in the clk_60mhz domain: gates writes of decoded samples into the
//  sample FIFO, holds off the transmitter until the FIFO is prefilled, converts frame requests from the
//  6.144 MHz frame assembler into single FIFO read pulses, and flushes/restarts on decode kill or underrun.
//  Sits between frame_dismantle, the sample FIFO, and the clock-domain crossing to frame_assembly.
// PARAMETERS
//  ACQ_FRAMES    192  consecutive valid samples, with no kill, required before prefill starts
//  FLUSH_CYCLES  8    cycles fifo_srst is held high per flush (min 1)
//  CNT_W         8    width of the saturating error counters
// PORTS
//  clk_60mhz        in   1      system clock
//  rst              in   1      reset, synchronous, active-high
//  enable           in   1      relay enable; low forces IDLE
//  kill             in   1      frame_dismantle framing-error abort
//  sample_valid     in   1      1-cycle pulse: new sample on dismantle data bus
//  frame_req_async  in   1      frame_ready level from 6.144 MHz domain (unsynchronised)
//  fifo_full        in   1      FIFO full
//  fifo_empty       in   1      FIFO empty
//  fifo_prog_empty  in   1      FIFO below programmable prefill threshold
//  fifo_wr_en       out  1      FIFO write strobe (combinational)
//  fifo_rd_en       out  1      FIFO read strobe (registered, 1-cycle pulse)
//  fifo_srst        out  1      FIFO synchronous reset (registered)
//  tx_enable        out  1      transmitter may consume data (registered)
//  state_out        out  3      current state encoding, for debug display
//  underrun_count   out  CNT_W  saturating count of underruns
//  overflow_count   out  CNT_W  saturating count of samples dropped on full
// BEHAVIOUR
//  Reset: state=FLUSH, flush counter=0, fifo_srst=1, fifo_rd_en=0, tx_enable=0, both counters=0,
//   synchroniser/edge flops=0. fifo_wr_en=0 while rst high.
//  States (state_out): IDLE=0, ACQUIRE=1, PREFILL=2, STREAM=3, FLUSH=4.
//  FLUSH:   fifo_srst=1 for FLUSH_CYCLES cycles, then -> IDLE (fifo_srst low on first IDLE cycle).
//  IDLE:    enable=1 -> ACQUIRE with acquire counter cleared.
//  ACQUIRE: counts sample_valid; any kill clears count; count reaching ACQ_FRAMES -> PREFILL next cycle.
//  PREFILL: writes enabled; fifo_prog_empty=0 -> STREAM.
//  STREAM:  tx_enable=1 (only state with tx_enable high); read requests serviced.
//  From ACQUIRE/PREFILL/STREAM: kill=1 -> FLUSH (kill outranks every other event that cycle);
//   enable=0 -> FLUSH. IDLE ignores kill.
//  fifo_wr_en = sample_valid & ~fifo_full & ~rst & state in {PREFILL, STREAM} & ~kill.
//  Overflow: sample_valid & fifo_full in PREFILL/STREAM -> sample dropped, overflow_count+1, saturates
//   at all-ones; no state change.
//  Read path: frame_req_async -> 2-flop synchroniser -> rising-edge detect; a request first sampled at
//   edge k yields fifo_rd_en high for exactly the cycle after edge k+2 (3-edge latency). Level held high
//   gives one pulse only; a new pulse needs the level to drop for >=1 synchronised cycle.
//  Requests outside STREAM are discarded (no pulse, not queued).
//  Underrun: request edge in STREAM with fifo_empty=1 -> no rd_en, underrun_count+1 (saturating),
//   -> FLUSH. Request edge with kill same cycle -> FLUSH, no rd_en, no underrun count.
//  Simultaneous write and read in STREAM both issued; controller does not track occupancy.
//  rst mid-operation: immediate return to reset values regardless of state; counters cleared.
// TESTING
//  Reset then enable=1, 192 sample_valid pulses -> state 0->1->2; fifo_wr_en low for all 192 pulses.
//  In PREFILL drop fifo_prog_empty -> STREAM next cycle, tx_enable=1; frame_req rise -> one rd_en 3 cycles later.
//  frame_req held high 100 cycles in STREAM -> exactly one fifo_rd_en pulse.
//  STREAM, fifo_empty=1, frame_req rise -> underrun_count=1, fifo_srst high 8 cycles, then IDLE.
//  kill at ACQUIRE count 150 -> FLUSH; kill same cycle as request edge in STREAM -> no rd_en, counts unchanged.
//  300 sample_valid with fifo_full=1 in STREAM -> 0 writes, overflow_count=255 (saturated).

Source files
------------

// File: rtl/spdif_relay_ctrl.sv
// S/PDIF relay sequencer (clk_60mhz domain).
// Gates sample writes into the relay FIFO, holds the transmitter off until the
// FIFO is prefilled, turns asynchronous frame requests into single read pulses,
// and flushes/restarts the FIFO on a decode kill, enable drop or underrun.
module spdif_relay_ctrl #(
  parameter int ACQ_FRAMES   = 192,
  parameter int FLUSH_CYCLES = 8,
  parameter int CNT_W        = 8
) (
  input  logic             clk_60mhz,
  input  logic             rst,
  input  logic             enable,
  input  logic             kill,
  input  logic             sample_valid,
  input  logic             frame_req_async,
  input  logic             fifo_full,
  input  logic             fifo_empty,
  input  logic             fifo_prog_empty,
  output logic             fifo_wr_en,
  output logic             fifo_rd_en,
  output logic             fifo_srst,
  output logic             tx_enable,
  output logic [2:0]       state_out,
  output logic [CNT_W-1:0] underrun_count,
  output logic [CNT_W-1:0] overflow_count
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ACQUIRE = 3'd1,
    PREFILL = 3'd2,
    STREAM  = 3'd3,
    FLUSH   = 3'd4
  } state_t;

  localparam int ACQ_W = $clog2(ACQ_FRAMES + 1);
  localparam int FL_W  = $clog2(FLUSH_CYCLES + 1);
  localparam logic [ACQ_W-1:0] ACQ_LAST = ACQ_W'(ACQ_FRAMES - 1);
  localparam logic [FL_W-1:0]  FL_LAST  = FL_W'(FLUSH_CYCLES - 1);

  state_t           state_q;
  logic [ACQ_W-1:0] acq_cnt_q;
  logic [FL_W-1:0]  flush_cnt_q;
  logic             srst_q;
  logic             rd_en_q;
  logic             tx_en_q;
  logic [CNT_W-1:0] underrun_q;
  logic [CNT_W-1:0] overflow_q;
  logic             sync1_q;
  logic             sync2_q;
  logic             req_prev_q;

  logic             req_edge;
  logic             wr_state;
  logic             overflow_evt;

  // Counters stick at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign wr_state     = (state_q == PREFILL) || (state_q == STREAM);
  assign req_edge     = sync2_q & ~req_prev_q;
  // A kill that cycle outranks the drop accounting just as it outranks writes.
  assign overflow_evt = wr_state & sample_valid & fifo_full & ~kill;

  assign fifo_wr_en     = sample_valid & ~fifo_full & ~rst & wr_state & ~kill;
  assign fifo_rd_en     = rd_en_q;
  assign fifo_srst      = srst_q;
  assign tx_enable      = tx_en_q;
  assign state_out      = state_q;
  assign underrun_count = underrun_q;
  assign overflow_count = overflow_q;

  // Two-flop synchroniser for the 6.144 MHz frame request, plus edge-detect history.
  always_ff @(posedge clk_60mhz) begin
    if (rst) begin
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      req_prev_q <= 1'b0;
    end else begin
      sync1_q    <= frame_req_async;
      sync2_q    <= sync1_q;
      req_prev_q <= sync2_q;
    end
  end

  // Sequencer FSM with registered FIFO/transmitter controls and error counters.
  always_ff @(posedge clk_60mhz) begin
    if (rst) begin
      state_q     <= FLUSH;
      acq_cnt_q   <= '0;
      flush_cnt_q <= '0;
      srst_q      <= 1'b1;
      rd_en_q     <= 1'b0;
      tx_en_q     <= 1'b0;
      underrun_q  <= '0;
      overflow_q  <= '0;
    end else begin
      rd_en_q <= 1'b0;
      if (overflow_evt) begin
        overflow_q <= sat_inc(overflow_q);
      end
      case (state_q)
        FLUSH: begin
          if (flush_cnt_q == FL_LAST) begin
            state_q     <= IDLE;
            srst_q      <= 1'b0;
            flush_cnt_q <= '0;
          end else begin
            flush_cnt_q <= flush_cnt_q + FL_W'(1);
          end
        end
        IDLE: begin
          if (enable) begin
            state_q   <= ACQUIRE;
            acq_cnt_q <= '0;
          end
        end
        ACQUIRE, PREFILL, STREAM: begin
          if (kill || !enable) begin
            state_q     <= FLUSH;
            srst_q      <= 1'b1;
            flush_cnt_q <= '0;
            tx_en_q     <= 1'b0;
            acq_cnt_q   <= '0;
          end else if (state_q == ACQUIRE) begin
            if (sample_valid) begin
              acq_cnt_q <= acq_cnt_q + ACQ_W'(1);
              if (acq_cnt_q == ACQ_LAST) begin
                state_q <= PREFILL;
              end
            end
          end else if (state_q == PREFILL) begin
            if (!fifo_prog_empty) begin
              state_q <= STREAM;
              tx_en_q <= 1'b1;
            end
          end else if (req_edge) begin
            // STREAM: a request against an empty FIFO is an underrun and restarts the relay.
            if (fifo_empty) begin
              underrun_q  <= sat_inc(underrun_q);
              state_q     <= FLUSH;
              srst_q      <= 1'b1;
              flush_cnt_q <= '0;
              tx_en_q     <= 1'b0;
            end else begin
              rd_en_q <= 1'b1;
            end
          end
        end
        default: begin
          state_q     <= FLUSH;
          srst_q      <= 1'b1;
          flush_cnt_q <= '0;
          tx_en_q     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spdif_relay_ctrl.sv
// Testbench for spdif_relay_ctrl: directed scenarios plus a randomized run
// compared against a behavioural model of the relay sequencing rules.
module tb_spdif_relay_ctrl;

  localparam int ACQ   = 192;
  localparam int FLUSH = 8;
  localparam int CMAX  = 255;

  logic clk = 1'b0;
  logic rst = 1'b1, enable = 1'b0, kill = 1'b0, sv = 1'b0, freq = 1'b0;
  logic full = 1'b0, empty = 1'b0, pe = 1'b1;
  logic       fifo_wr_en, fifo_rd_en, fifo_srst, tx_enable;
  logic [2:0] state_out;
  logic [7:0] underrun_count, overflow_count;

  int errs = 0, checks = 0;

  // model state: phase numbers follow the debug encoding of the relay phases
  int m_st = 4, m_acq = 0, m_fc = 0, m_under = 0, m_over = 0;
  bit m_srst = 1, m_rd = 0, m_tx = 0;
  bit req_hist[3] = '{0, 0, 0};   // [0] newest sampled request level
  bit obs_wr, exp_wr;
  int dut_wr_cnt = 0;

  spdif_relay_ctrl #(.ACQ_FRAMES(ACQ), .FLUSH_CYCLES(FLUSH), .CNT_W(8)) dut (
    .clk_60mhz(clk), .rst(rst), .enable(enable), .kill(kill),
    .sample_valid(sv), .frame_req_async(freq), .fifo_full(full),
    .fifo_empty(empty), .fifo_prog_empty(pe), .fifo_wr_en(fifo_wr_en),
    .fifo_rd_en(fifo_rd_en), .fifo_srst(fifo_srst), .tx_enable(tx_enable),
    .state_out(state_out), .underrun_count(underrun_count),
    .overflow_count(overflow_count));

  always #5 clk = ~clk;

  function automatic int sat(input int v);
    return (v >= CMAX) ? CMAX : v + 1;
  endfunction

  // One clock: sample the write strobe, advance the model on the edge, return at negedge.
  task automatic step();
    bit req_seen;
    bit streaming;
    #1;
    streaming = (m_st == 2) || (m_st == 3);
    obs_wr = fifo_wr_en;
    exp_wr = sv && !full && !rst && streaming && !kill;
    if (obs_wr) dut_wr_cnt++;
    @(posedge clk);
    if (rst) begin
      m_st = 4; m_acq = 0; m_fc = 0; m_srst = 1; m_rd = 0; m_tx = 0;
      m_under = 0; m_over = 0; req_hist = '{0, 0, 0};
    end else begin
      // a request is seen once the synchronised level rises (two samples old vs three)
      req_seen = req_hist[1] && !req_hist[2];
      m_rd = 0;
      if (streaming && sv && full && !kill) m_over = sat(m_over);
      if (m_st == 4) begin
        if (m_fc == FLUSH - 1) begin m_st = 0; m_srst = 0; m_fc = 0; end
        else m_fc++;
      end else if (m_st == 0) begin
        if (enable) begin m_st = 1; m_acq = 0; end
      end else if (kill || !enable) begin
        m_st = 4; m_srst = 1; m_fc = 0; m_tx = 0; m_acq = 0;
      end else if (m_st == 1) begin
        if (sv) begin
          m_acq++;
          if (m_acq == ACQ) m_st = 2;
        end
      end else if (m_st == 2) begin
        if (!pe) begin m_st = 3; m_tx = 1; end
      end else if (req_seen) begin
        if (empty) begin
          m_under = sat(m_under); m_st = 4; m_srst = 1; m_fc = 0; m_tx = 0;
        end else m_rd = 1;
      end
      req_hist[2] = req_hist[1];
      req_hist[1] = req_hist[0];
      req_hist[0] = freq;
    end
    @(negedge clk);
  endtask

  // Drive a fresh relay run up to STREAM; used as setup by several scenarios.
  task automatic go_stream();
    int n = 0;
    rst = 0; kill = 0; enable = 1; sv = 0; freq = 0; full = 0; empty = 0; pe = 1;
    while (state_out != 3'd1 && n < 40) begin step(); n++; end
    for (int i = 0; i < ACQ; i++) begin sv = 1; step(); end
    sv = 0; pe = 0; step(); pe = 1;
    checks++;
    if (state_out !== 3'd3) begin
      errs++; $display("FAIL reach_stream: state=%0d required 3", state_out);
    end
  endtask

  task automatic test_reset();
    rst = 1; sv = 1; full = 0;
    step(); step(); step();
    checks++;
    if ({state_out, fifo_srst, fifo_rd_en, tx_enable} !== {3'd4, 1'b1, 1'b0, 1'b0}) begin
      errs++; $display("FAIL reset_state: state=%0d srst=%b rd=%b tx=%b required 4/1/0/0",
                       state_out, fifo_srst, fifo_rd_en, tx_enable);
    end
    checks++;
    if ({underrun_count, overflow_count} !== 16'h0) begin
      errs++; $display("FAIL reset_counts: under=%0d over=%0d required 0/0", underrun_count, overflow_count);
    end
    checks++;
    if (obs_wr !== 1'b0) begin
      errs++; $display("FAIL reset_wr: wr_en=%b required 0", obs_wr);
    end
    sv = 0; rst = 0;
    for (int i = 0; i < FLUSH - 1; i++) step();
    checks++;
    if ({state_out, fifo_srst} !== {3'd4, 1'b1}) begin
      errs++; $display("FAIL flush_hold: state=%0d srst=%b required 4/1", state_out, fifo_srst);
    end
    step();
    checks++;
    if ({state_out, fifo_srst} !== {3'd0, 1'b0}) begin
      errs++; $display("FAIL flush_end: state=%0d srst=%b required 0/0", state_out, fifo_srst);
    end
  endtask

  task automatic test_acquire_prefill();
    enable = 1; step();
    checks++;
    if (state_out !== 3'd1) begin errs++; $display("FAIL acquire_entry: state=%0d required 1", state_out); end
    dut_wr_cnt = 0;
    for (int i = 0; i < ACQ - 1; i++) begin sv = 1; step(); end
    checks++;
    if (state_out !== 3'd1) begin errs++; $display("FAIL acquire_191: state=%0d required 1", state_out); end
    step(); sv = 0;
    checks++;
    if (state_out !== 3'd2) begin errs++; $display("FAIL prefill_entry: state=%0d required 2", state_out); end
    checks++;
    if (dut_wr_cnt !== 0) begin errs++; $display("FAIL acquire_writes: writes=%0d required 0", dut_wr_cnt); end
    sv = 1; step(); sv = 0;
    checks++;
    if (obs_wr !== 1'b1) begin errs++; $display("FAIL prefill_write: wr_en=%b required 1", obs_wr); end
    checks++;
    if ({state_out, tx_enable} !== {3'd2, 1'b0}) begin
      errs++; $display("FAIL prefill_hold: state=%0d tx=%b required 2/0", state_out, tx_enable);
    end
    pe = 0; step(); pe = 1;
    checks++;
    if ({state_out, tx_enable} !== {3'd3, 1'b1}) begin
      errs++; $display("FAIL stream_entry: state=%0d tx=%b required 3/1", state_out, tx_enable);
    end
  endtask

  task automatic test_read_latency();
    int first = -1, pulses = 0;
    freq = 1;
    for (int i = 1; i <= 6; i++) begin
      step();
      if (fifo_rd_en) begin pulses++; if (first < 0) first = i; end
    end
    freq = 0; step(); step(); step();
    checks++;
    if (first !== 3 || pulses !== 1) begin
      errs++; $display("FAIL read_latency: first=%0d pulses=%0d required 3/1", first, pulses);
    end
  endtask

  task automatic test_held_request();
    int pulses = 0;
    freq = 1;
    for (int i = 0; i < 100; i++) begin step(); if (fifo_rd_en) pulses++; end
    freq = 0; step(); step(); step();
    checks++;
    if (pulses !== 1) begin errs++; $display("FAIL held_request: pulses=%0d required 1", pulses); end
    pulses = 0;
    freq = 1; step(); freq = 0;
    for (int i = 0; i < 5; i++) begin if (fifo_rd_en) pulses++; step(); end
    checks++;
    if (pulses !== 1) begin errs++; $display("FAIL short_request: pulses=%0d required 1", pulses); end
  endtask

  task automatic test_kill_request();
    int pulses = 0;
    go_stream();
    freq = 1; step(); step();
    kill = 1; step(); kill = 0;
    for (int i = 0; i < 3; i++) begin if (fifo_rd_en) pulses++; step(); end
    freq = 0;
    checks++;
    if (pulses !== 0 || underrun_count !== 8'd0) begin
      errs++; $display("FAIL kill_request: pulses=%0d under=%0d required 0/0", pulses, underrun_count);
    end
    checks++;
    if (state_out !== 3'd4) begin errs++; $display("FAIL kill_flush: state=%0d required 4", state_out); end
  endtask

  task automatic test_underrun();
    int srst_cnt = 1, pulses = 0;
    go_stream();
    empty = 1; freq = 1;
    step(); step(); step();
    checks++;
    if ({state_out, fifo_srst, tx_enable, fifo_rd_en} !== {3'd4, 1'b1, 1'b0, 1'b0} || underrun_count !== 8'd1) begin
      errs++; $display("FAIL underrun: state=%0d srst=%b tx=%b rd=%b under=%0d required 4/1/0/0/1",
                       state_out, fifo_srst, tx_enable, fifo_rd_en, underrun_count);
    end
    freq = 0; empty = 0; enable = 0;
    for (int i = 0; i < 12; i++) begin step(); if (fifo_srst) srst_cnt++; if (fifo_rd_en) pulses++; end
    checks++;
    if (srst_cnt !== FLUSH || state_out !== 3'd0 || pulses !== 0) begin
      errs++; $display("FAIL underrun_flush: srst_cycles=%0d state=%0d rd=%0d required %0d/0/0",
                       srst_cnt, state_out, pulses, FLUSH);
    end
  endtask

  task automatic test_kill_acquire();
    enable = 1; step();
    for (int i = 0; i < 150; i++) begin sv = 1; step(); end
    sv = 0; kill = 1; step(); kill = 0;
    checks++;
    if ({state_out, fifo_srst} !== {3'd4, 1'b1}) begin
      errs++; $display("FAIL kill_acquire: state=%0d srst=%b required 4/1", state_out, fifo_srst);
    end
  endtask

  task automatic test_overflow();
    go_stream();
    dut_wr_cnt = 0; full = 1;
    for (int i = 0; i < 300; i++) begin sv = 1; step(); end
    sv = 0; full = 0;
    checks++;
    if (dut_wr_cnt !== 0 || overflow_count !== 8'd255 || state_out !== 3'd3) begin
      errs++; $display("FAIL overflow: writes=%0d over=%0d state=%0d required 0/255/3",
                       dut_wr_cnt, overflow_count, state_out);
    end
    rst = 1; step(); rst = 0;
    checks++;
    if ({state_out, fifo_srst, tx_enable} !== {3'd4, 1'b1, 1'b0} || overflow_count !== 8'd0) begin
      errs++; $display("FAIL mid_reset: state=%0d srst=%b tx=%b over=%0d required 4/1/0/0",
                       state_out, fifo_srst, tx_enable, overflow_count);
    end
  endtask

  task automatic test_random();
    logic [22:0] obs, exp;
    int shown = 0;
    for (int c = 0; c < 6000; c++) begin
      rst    = ($urandom_range(1999) == 0);
      enable = ($urandom_range(999) != 0);
      kill   = ($urandom_range(999) == 0);
      sv     = $urandom_range(1);
      full   = ($urandom_range(19) == 0);
      empty  = ($urandom_range(9) == 0);
      pe     = $urandom_range(1);
      if ($urandom_range(5) == 0) freq = ~freq;
      step();
      obs = {state_out, fifo_rd_en, fifo_srst, tx_enable, underrun_count, overflow_count, obs_wr};
      exp = {3'(m_st), m_rd, m_srst, m_tx, 8'(m_under), 8'(m_over), exp_wr};
      checks++;
      if (obs !== exp) begin
        errs++;
        if (shown < 10) begin
          shown++;
          $display("FAIL random cycle %0d: got %h required %h", c, obs, exp);
        end
      end
    end
    rst = 0; kill = 0; sv = 0; freq = 0;
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_acquire_prefill();
    test_read_latency();
    test_held_request();
    test_kill_request();
    test_underrun();
    test_kill_acquire();
    test_overflow();
    test_random();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
